mul5_stim_gen: RTL and testbench

- Sequential stimulus source paired with the 6-bit multiple-of-5 detector; the producer end of the detector's din/en interface.
- On `start`, streams a sequence of WIDTH-bit words over a valid/ready handshake.
- Each word carries a golden "is multiple of DIVISOR" flag, computed by an incrementally tracked remainder (no divider).
- A checker compares the detector's `dout` against the golden flag.

---
 rtl/mul5_pkg.sv | 18 +
 rtl/mul5_stim_gen_mod_counter.sv | 31 +++
 rtl/mul5_stim_gen.sv | 134 +++++++++++++
 tb/tb_mul5_stim_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul5_pkg.sv
// Shared types and defaults for the multiple-of-5 stimulus generator family.
// No logic; constants and the generator FSM state encoding.
// Not applicable (no handshake).
package mul5_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL5_WIDTH   = 6;
    localparam int MUL5_DIVISOR = 5;

    localparam logic MODE_SWEEP = 1'b0;
    localparam logic MODE_MULT  = 1'b1;

endpackage

// File: rtl/mul5_stim_gen_mod_counter.sv
// Remainder counter: counts 0..DIVISOR-1 on inc and wraps, clr forces 0 (clr wins).
// Latency: rem updates on the edge after clr/inc; is_zero is a decode of rem.
// Backpressure: none, the caller only pulses inc for accepted words.
module mod_counter #(
    parameter int DIVISOR = 5,
    parameter int RW      = $clog2(DIVISOR)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] rem,
    output logic          is_zero
);

    localparam logic [RW-1:0] LAST_REM = RW'(DIVISOR - 1);

    // Remainder register: clear has priority, increment wraps at DIVISOR-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem <= '0;
        end else if (clr) begin
            rem <= '0;
        end else if (inc) begin
            rem <= (rem == LAST_REM) ? '0 : rem + RW'(1);
        end
    end

    assign is_zero = (rem == '0);

endmodule

// File: rtl/mul5_stim_gen.sv
// Streams words 0..2^WIDTH-1 (or multiples of DIVISOR) with a golden multiple flag.
// Latency: first word valid one cycle after start; one word per cycle when out_ready stays high.
// Backpressure: out_ready low stalls the stream with dout/exp_mul held; stop aborts immediately.
module mul5_stim_gen
    import mul5_pkg::*;
#(
    parameter int WIDTH   = MUL5_WIDTH,
    parameter int DIVISOR = MUL5_DIVISOR
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] dout,
    output logic             exp_mul,
    output logic             out_en,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int               RW       = $clog2(DIVISOR);
    localparam logic [RW-1:0]    LAST_REM = RW'(DIVISOR - 1);
    localparam logic [WIDTH:0]   DIV_X    = (WIDTH + 1)'(DIVISOR);
    localparam logic [WIDTH-1:0] DIV_W    = WIDTH'(DIVISOR);

    state_t           state, state_d;
    logic [WIDTH-1:0] cur, cur_d;
    logic             mode_q, mode_d;
    logic             exp_d, out_en_d, busy_d, done_d;
    logic             rem_clr, rem_inc;
    logic [RW-1:0]    rem;
    logic             rem_zero;
    logic [WIDTH:0]   cur_step;
    logic             xfer;
    logic             last_word;

    mod_counter #(
        .DIVISOR (DIVISOR),
        .RW      (RW)
    ) u_rem (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (rem_clr),
        .inc     (rem_inc),
        .rem     (rem),
        .is_zero (rem_zero)
    );

    // The step is formed one bit wider so the multiples-only end test cannot wrap.
    assign cur_step  = {1'b0, cur} + DIV_X;
    assign xfer      = out_en && out_ready;
    assign last_word = (mode_q == MODE_MULT) ? cur_step[WIDTH] : (cur == '1);
    assign dout      = cur;

    // Next-state and next-output decode; stop overrides everything, including a coincident handshake.
    always_comb begin
        state_d  = state;
        cur_d    = cur;
        mode_d   = mode_q;
        exp_d    = exp_mul;
        out_en_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        rem_clr  = 1'b0;
        rem_inc  = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_d  = RUN;
                        mode_d   = mode;
                        cur_d    = '0;
                        rem_clr  = 1'b1;
                        exp_d    = 1'b1;
                        out_en_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
                RUN: begin
                    out_en_d = 1'b1;
                    busy_d   = 1'b1;
                    if (xfer) begin
                        if (last_word) begin
                            state_d  = DONE;
                            out_en_d = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else if (mode_q == MODE_MULT) begin
                            // Remainder is never advanced in this mode, so it stays zero.
                            cur_d = cur + DIV_W;
                            exp_d = rem_zero;
                        end else begin
                            cur_d   = cur + WIDTH'(1);
                            rem_inc = 1'b1;
                            exp_d   = (rem == LAST_REM);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, word and registered output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cur     <= '0;
            mode_q  <= MODE_SWEEP;
            exp_mul <= 1'b0;
            out_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cur     <= cur_d;
            mode_q  <= mode_d;
            exp_mul <= exp_d;
            out_en  <= out_en_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_mul5_stim_gen.sv
// Scoreboard bench for mul5_stim_gen: driver queues expected words, monitor checks each handshake.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
// Stalls are checked for held outputs; stop and reset-abort paths are checked for silence.
module tb_mul5_stim_gen;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       mode;
    logic [5:0] dout;
    logic       exp_mul;
    logic       out_en;
    logic       out_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    logic [6:0] exp_q[$];

    logic       prev_stall = 1'b0;
    logic [5:0] prev_dout  = '0;
    logic       prev_exp   = 1'b0;

    mul5_stim_gen dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dout      (dout),
        .exp_mul   (exp_mul),
        .out_en    (out_en),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({6'(i), (i % 5) == 0});
    endtask

    task automatic push_mult();
        for (int i = 0; i <= 60; i += 5) exp_q.push_back({6'(i), 1'b1});
    endtask

    // Accept a start and check the first word; mode is flipped afterwards to show it is latched.
    task automatic do_start(input logic m);
        start = 1'b1;
        mode  = m;
        run_cycle();
        start = 1'b0;
        mode  = ~m;
        check("first_en", int'(out_en), 1);
        check("first_dout", int'(dout), 0);
        check("first_exp", int'(exp_mul), 1);
        check("first_busy", int'(busy), 1);
    endtask

    task automatic wait_dout(input int val, input int budget);
        int n = 0;
        while (!(out_en && dout == 6'(val)) && n < budget) begin
            run_cycle();
            n++;
        end
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_dout: timeout waiting for dout=%0d, got %0d", val, dout);
        end
    endtask

    task automatic wait_done(input int budget, input bit toggle, output int en_cycles);
        int n = 0;
        en_cycles = 0;
        while (!done && n < budget) begin
            if (out_en) en_cycles++;
            if (toggle) out_ready = ~out_ready;
            run_cycle();
            n++;
        end
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_done: timeout, done=%0d", done);
        end
        out_ready = 1'b1;
    endtask

    // Monitor: every accepted word is popped from the scoreboard; stalled words must hold still.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall && out_en) begin
                check("stall_dout", int'(dout), int'(prev_dout));
                check("stall_exp", int'(exp_mul), int'(prev_exp));
            end
            if (out_en && out_ready && !stop) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got dout=%0d, required no word", dout);
                end else begin
                    logic [6:0] e;
                    e = exp_q.pop_front();
                    check("word_dout", int'(dout), int'(e[6:1]));
                    check("word_exp", int'(exp_mul), int'(e[0]));
                end
            end
            prev_stall = out_en && !out_ready && !stop;
            prev_dout  = dout;
            prev_exp   = exp_mul;
        end
    end

    initial begin
        int en_cycles;
        rstn      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_dout", int'(dout), 0);
        check("rst_exp", int'(exp_mul), 0);
        check("rst_en", int'(out_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rstn = 1'b1;
        run_cycle();
        run_cycle();
        check("idle_en", int'(out_en), 0);

        // Full sweep, back-to-back.
        done_cnt = 0; xfer_cnt = 0;
        push_sweep(64);
        do_start(1'b0);
        wait_done(200, 1'b0, en_cycles);
        check("sweep_en_cycles", en_cycles, 64);
        run_cycle();
        check("sweep_done_cnt", done_cnt, 1);
        check("sweep_xfers", xfer_cnt, 64);
        check("sweep_en_after", int'(out_en), 0);
        check("sweep_q_empty", exp_q.size(), 0);

        // Multiples only.
        done_cnt = 0; xfer_cnt = 0;
        push_mult();
        do_start(1'b1);
        wait_done(100, 1'b0, en_cycles);
        check("mult_en_cycles", en_cycles, 13);
        run_cycle();
        run_cycle();
        check("mult_done_cnt", done_cnt, 1);
        check("mult_xfers", xfer_cnt, 13);
        check("mult_en_after", int'(out_en), 0);
        check("mult_q_empty", exp_q.size(), 0);

        // Full sweep with out_ready toggling.
        done_cnt = 0; xfer_cnt = 0;
        push_sweep(64);
        do_start(1'b0);
        wait_done(400, 1'b1, en_cycles);
        run_cycle();
        check("stall_done_cnt", done_cnt, 1);
        check("stall_xfers", xfer_cnt, 64);
        check("stall_q_empty", exp_q.size(), 0);

        // Stop at word 17, then restart from 0.
        done_cnt = 0; xfer_cnt = 0;
        push_sweep(17);
        do_start(1'b0);
        wait_dout(17, 100);
        stop = 1'b1;
        run_cycle();
        stop = 1'b0;
        check("stop_en", int'(out_en), 0);
        check("stop_busy", int'(busy), 0);
        run_cycle();
        check("stop_en_idle", int'(out_en), 0);
        check("stop_done_cnt", done_cnt, 0);
        check("stop_xfers", xfer_cnt, 17);
        check("stop_q_empty", exp_q.size(), 0);
        push_sweep(64);
        do_start(1'b0);
        wait_done(200, 1'b0, en_cycles);
        run_cycle();
        check("restart_done_cnt", done_cnt, 1);
        check("restart_q_empty", exp_q.size(), 0);

        // Start while running and while in DONE is ignored.
        done_cnt = 0; xfer_cnt = 0;
        push_sweep(64);
        do_start(1'b0);
        wait_dout(10, 100);
        start = 1'b1;
        run_cycle();
        start = 1'b0;
        wait_done(200, 1'b0, en_cycles);
        start = 1'b1;
        run_cycle();
        start = 1'b0;
        check("done_start_en", int'(out_en), 0);
        run_cycle();
        check("done_start_en2", int'(out_en), 0);
        check("done_start_busy", int'(busy), 0);
        check("rerun_done_cnt", done_cnt, 1);
        check("rerun_xfers", xfer_cnt, 64);
        check("rerun_q_empty", exp_q.size(), 0);

        // Asynchronous reset while stalled at word 33.
        done_cnt = 0;
        push_sweep(33);
        do_start(1'b0);
        wait_dout(33, 100);
        out_ready = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_dout", int'(dout), 0);
        check("arst_exp", int'(exp_mul), 0);
        check("arst_en", int'(out_en), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        run_cycle();
        run_cycle();
        run_cycle();
        check("post_rst_en", int'(out_en), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_dout", int'(dout), 0);
        check("post_rst_done_cnt", done_cnt, 0);
        check("post_rst_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
